// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the play-state controller and the renderer.
package game_sequencer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_ATTRACT = 2'd0,
    ST_PLAY    = 2'd1,
    ST_DYING   = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_sequencer_btn_debounce.sv
// Move-button conditioning: 2-flop synchronizer, frame-rate debounce, rising-edge press pulse.
module btn_debounce #(
  parameter int DB_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic frame_tick_i,
  output logic btn_db_o,
  output logic press_o
);

  logic [1:0] sync_q;
  logic       db_q, db_d;
  logic [3:0] cnt_q, cnt_d;
  logic       press_q, press_d;

  // synchronize the asynchronous pin into the clk domain
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], btn_i};
  end

  // count consecutive frame samples that disagree with the debounced level
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (frame_tick_i) begin
      if (sync_q[1] == db_q) begin
        cnt_d = 4'd0;
      end else if (cnt_q == 4'(DB_FRAMES - 1)) begin
        db_d  = sync_q[1];
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    press_d = db_d & ~db_q;
  end

  // debounce state and press pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q    <= 1'b0;
      cnt_q   <= 4'd0;
      press_q <= 1'b0;
    end else begin
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign btn_db_o = db_q;
  assign press_o  = press_q;

endmodule

// File: rtl/game_sequencer.sv
// Play-state controller: attract/play/dying/over sequencing, collision latch,
// frame counter, death flash and high score for the vertical scroller.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int DB_FRAMES    = 3,
  parameter int DIE_FRAMES   = 60,
  parameter int FLASH_FRAMES = 8,
  parameter int IDLE_FRAMES  = 250,
  parameter int WIN_SCORE    = 99
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_in,
  input  logic         frame_tick,
  input  logic         collision,
  input  logic [7:0]   score,
  output logic         scroll_rst,
  output logic         scroll_move,
  output logic [1:0]   state,
  output logic         flash,
  output logic         win,
  output logic [7:0]   high_score
);

  localparam logic [7:0] DIE_LAST   = 8'(DIE_FRAMES - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(IDLE_FRAMES - 1);
  localparam logic [7:0] FLASH_DIV  = 8'(FLASH_FRAMES);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0] WIN_VAL    = 8'(WIN_SCORE);

  logic btn_db, press;

  state_e     state_q, state_d;
  logic       restart_q, restart_d;
  logic       coll_q, coll_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       flash_q, flash_d;
  logic       win_q, win_d;
  logic [7:0] hs_q, hs_d;
  logic       scroll_rst_q, scroll_rst_d;
  logic       scroll_move_q, scroll_move_d;
  logic       coll_hit;

  btn_debounce #(.DB_FRAMES(DB_FRAMES)) u_btn (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_i        (btn_in),
    .frame_tick_i (frame_tick),
    .btn_db_o     (btn_db),
    .press_o      (press)
  );

  // a collision on the tick cycle still belongs to the frame that is ending
  assign coll_hit = coll_q | collision;

  // next-state, win flag, restart marker and high-score update
  always_comb begin
    state_d   = state_q;
    restart_d = restart_q;
    win_d     = win_q;
    hs_d      = hs_q;
    case (state_q)
      ST_ATTRACT: begin
        // restart_q marks the single scroller-reset cycle of a restart from OVER
        if (restart_q) begin
          state_d   = ST_PLAY;
          restart_d = 1'b0;
        end else if (press) begin
          state_d = ST_PLAY;
          win_d   = 1'b0;
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (coll_hit) begin
            state_d = ST_DYING;
            hs_d    = max8(hs_q, score);
          end else if (score == WIN_VAL) begin
            state_d = ST_OVER;
            win_d   = 1'b1;
            hs_d    = max8(hs_q, score);
          end
        end
      end
      ST_DYING: begin
        if (frame_tick && frame_cnt_q == DIE_LAST) state_d = ST_OVER;
      end
      ST_OVER: begin
        if (press) begin
          state_d   = ST_ATTRACT;
          restart_d = 1'b1;
          win_d     = 1'b0;
        end else if (frame_tick && frame_cnt_q == IDLE_LAST) begin
          state_d = ST_ATTRACT;
        end
      end
      default: state_d = ST_ATTRACT;
    endcase
  end

  // collision latch, frame counter, flash and registered scroller controls
  always_comb begin
    coll_d = coll_q;
    if (frame_tick)                          coll_d = 1'b0;
    else if (collision && state_q == ST_PLAY) coll_d = 1'b1;

    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q)                    frame_cnt_d = 8'd0;
    else if (frame_tick && frame_cnt_q != 8'hFF) frame_cnt_d = frame_cnt_q + 8'd1;

    flash_d = flash_q;
    if (state_q == ST_DYING && frame_tick && (frame_cnt_q % FLASH_DIV) == FLASH_LAST)
      flash_d = ~flash_q;
    if (state_d != ST_DYING) flash_d = 1'b0;

    // keyed off the next state so these line up with the state output
    scroll_rst_d  = (state_d == ST_ATTRACT);
    scroll_move_d = btn_db & (state_d == ST_PLAY);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_ATTRACT;
      restart_q     <= 1'b0;
      coll_q        <= 1'b0;
      frame_cnt_q   <= 8'd0;
      flash_q       <= 1'b0;
      win_q         <= 1'b0;
      hs_q          <= 8'd0;
      scroll_rst_q  <= 1'b1;
      scroll_move_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      restart_q     <= restart_d;
      coll_q        <= coll_d;
      frame_cnt_q   <= frame_cnt_d;
      flash_q       <= flash_d;
      win_q         <= win_d;
      hs_q          <= hs_d;
      scroll_rst_q  <= scroll_rst_d;
      scroll_move_q <= scroll_move_d;
    end
  end

  assign state       = state_q;
  assign scroll_rst  = scroll_rst_q;
  assign scroll_move = scroll_move_q;
  assign flash       = flash_q;
  assign win         = win_q;
  assign high_score  = hs_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: debounce, death, win, restart, idle and reset.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_in = 1'b0;
  logic       frame_tick = 1'b0;
  logic       collision = 1'b0;
  logic [7:0] score = 8'd0;
  logic       scroll_rst, scroll_move, flash, win;
  logic [1:0] state;
  logic [7:0] high_score;

  int checks = 0;
  int failures = 0;

  always #20 clk = ~clk;

  game_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .frame_tick  (frame_tick),
    .collision   (collision),
    .score       (score),
    .scroll_rst  (scroll_rst),
    .scroll_move (scroll_move),
    .state       (state),
    .flash       (flash),
    .win         (win),
    .high_score  (high_score)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // all driving and sampling happens on the falling edge
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one frame_tick pulse; returns just after the rising edge that consumed it
  task automatic tick();
    cyc(3);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // from OVER with the button held: release, press again, expect one ATTRACT cycle then PLAY
  task automatic restart_from_over();
    btn_in = 1'b0;
    ticks(3);
    btn_in = 1'b1;
    ticks(3);
    chk("restart_still_over", state, 8'd3);
    cyc(1);
    chk("restart_pulse_state", state, 8'd0);
    chk("restart_pulse_rst", scroll_rst, 8'd1);
    chk("restart_pulse_win", win, 8'd0);
    cyc(1);
    chk("restart_play_state", state, 8'd1);
    chk("restart_play_rst", scroll_rst, 8'd0);
    chk("restart_play_win", win, 8'd0);
  endtask

  initial begin
    // reset values
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    chk("rst_state", state, 8'd0);
    chk("rst_scroll_rst", scroll_rst, 8'd1);
    chk("rst_scroll_move", scroll_move, 8'd0);
    chk("rst_flash", flash, 8'd0);
    chk("rst_win", win, 8'd0);
    chk("rst_high_score", high_score, 8'd0);

    // bounce across two frames, then three stable frames
    btn_in = 1'b1; tick();
    btn_in = 1'b0; tick();
    btn_in = 1'b1; tick();
    tick();
    chk("db_no_early_2", state, 8'd0);
    tick();
    chk("db_no_early_3", state, 8'd0);
    cyc(1);
    chk("db_play_state", state, 8'd1);
    chk("db_play_rst", scroll_rst, 8'd0);
    chk("db_play_move", scroll_move, 8'd1);
    chk("db_play_win", win, 8'd0);

    // collision several clocks ahead of the tick, score 42
    score = 8'd42;
    cyc(2);
    collision = 1'b1;
    cyc(1);
    collision = 1'b0;
    chk("death_wait_tick", state, 8'd1);
    tick();
    chk("death_state", state, 8'd2);
    chk("death_high_score", high_score, 8'd42);
    chk("death_move", scroll_move, 8'd0);
    chk("death_flash0", flash, 8'd0);
    chk("death_scroll_rst", scroll_rst, 8'd0);

    // flash toggles every 8 DYING ticks; OVER after the 60th with flash low
    for (int k = 1; k <= 60; k++) begin
      if (k == 30) begin
        collision = 1'b1;
        cyc(1);
        collision = 1'b0;
      end
      tick();
      chk($sformatf("dying_flash_%0d", k), flash, (k < 60) ? 8'((k / 8) % 2) : 8'd0);
      chk($sformatf("dying_state_%0d", k), state, (k < 60) ? 8'd2 : 8'd3);
    end
    chk("over_win", win, 8'd0);
    chk("over_high_score", high_score, 8'd42);

    // collision in OVER and a held button do nothing
    collision = 1'b1;
    cyc(1);
    collision = 1'b0;
    ticks(3);
    chk("over_held_no_press", state, 8'd3);
    restart_from_over();

    // collision coincident with frame_tick
    cyc(3);
    collision = 1'b1;
    frame_tick = 1'b1;
    cyc(1);
    collision = 1'b0;
    frame_tick = 1'b0;
    chk("same_cycle_dying", state, 8'd2);
    ticks(60);
    chk("same_cycle_over", state, 8'd3);
    restart_from_over();

    // win at score 99
    score = 8'd99;
    tick();
    chk("win_state", state, 8'd3);
    chk("win_flag", win, 8'd1);
    chk("win_high_score", high_score, 8'd99);
    restart_from_over();

    // score 99 plus collision in the same frame: death, not win
    cyc(1);
    collision = 1'b1;
    cyc(1);
    collision = 1'b0;
    tick();
    chk("win_vs_coll_state", state, 8'd2);
    chk("win_vs_coll_win", win, 8'd0);
    ticks(60);
    chk("idle_enter_over", state, 8'd3);
    score = 8'd0;

    // idle timeout with the button still held
    ticks(249);
    chk("idle_249_over", state, 8'd3);
    chk("idle_hs_held", high_score, 8'd99);
    tick();
    chk("idle_attract", state, 8'd0);
    chk("idle_scroll_rst", scroll_rst, 8'd1);
    ticks(3);
    chk("idle_held_stays", state, 8'd0);

    // back to PLAY, then reset held 3 clocks
    btn_in = 1'b0;
    ticks(3);
    btn_in = 1'b1;
    ticks(3);
    cyc(1);
    chk("pre_reset_play", state, 8'd1);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    chk("reset2_state", state, 8'd0);
    chk("reset2_scroll_rst", scroll_rst, 8'd1);
    chk("reset2_high_score", high_score, 8'd0);
    chk("reset2_move", scroll_move, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
